// File: rtl/nrzi_rx_deser.sv
// NRZI line receiver: decodes toggle-on-one bits, hunts for a sync word, then
// assembles LSB-first words into a one-entry valid/ready holding register.
module nrzi_rx_deser #(
   parameter int               WIDTH      = 8,
   parameter logic [WIDTH-1:0] SYNC       = 8'hD5,
   parameter logic             IDLE_LEVEL = 1'b0,
   parameter int               IDLE_RUN   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_en,
   input  logic             line,
   input  logic             flush,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             locked,
   output logic             overflow
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int ZW = $clog2(IDLE_RUN + 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic {HUNT, LOCKED} state_t;

   state_t           state_reg, state_next;
   logic             prev_line_reg;
   logic [WIDTH-1:0] hunt_reg;
   logic [WIDTH-1:0] asm_reg;
   logic [CW-1:0]    bit_cnt_reg;
   logic [ZW-1:0]    zero_cnt_reg;

   logic             d;
   logic [WIDTH-1:0] hunt_shift;
   logic [WIDTH-1:0] asm_shift;
   logic [ZW-1:0]    zero_next;
   logic             run_out;
   logic             sync_hit;
   logic             word_done;

   assign d          = line ^ prev_line_reg;
   assign hunt_shift = {d, hunt_reg[WIDTH-1:1]};
   assign asm_shift  = {d, asm_reg[WIDTH-1:1]};
   assign zero_next  = d ? '0 : zero_cnt_reg + ZW'(1);
   assign run_out    = (zero_next == ZW'(IDLE_RUN));
   assign sync_hit   = (hunt_shift == SYNC);

   // A bit that ends the idle run discards the word, even on a word boundary.
   assign word_done  = bit_en && !flush && (state_reg == LOCKED) && !run_out
                       && (bit_cnt_reg == LAST_BIT);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_reg <= HUNT;
      else      state_reg <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      if (flush) begin
         state_next = HUNT;
      end else if (bit_en) begin
         case (state_reg)
            HUNT:    if (sync_hit) state_next = LOCKED;
            LOCKED:  if (run_out)  state_next = HUNT;
            default: state_next = HUNT;
         endcase
      end
   end

   // Output logic
   always_comb begin
      locked = (state_reg == LOCKED);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         prev_line_reg <= IDLE_LEVEL;
         hunt_reg      <= '0;
         asm_reg       <= '0;
         bit_cnt_reg   <= '0;
         zero_cnt_reg  <= '0;
      end else begin
         if (bit_en) prev_line_reg <= line;
         if (flush) begin
            hunt_reg     <= '0;
            asm_reg      <= '0;
            bit_cnt_reg  <= '0;
            zero_cnt_reg <= '0;
         end else if (bit_en) begin
            if (state_reg == HUNT) begin
               hunt_reg     <= hunt_shift;
               asm_reg      <= '0;
               bit_cnt_reg  <= '0;
               zero_cnt_reg <= '0;
            end else if (run_out) begin
               hunt_reg     <= '0;
               asm_reg      <= '0;
               bit_cnt_reg  <= '0;
               zero_cnt_reg <= '0;
            end else begin
               asm_reg      <= asm_shift;
               bit_cnt_reg  <= (bit_cnt_reg == LAST_BIT) ? '0 : bit_cnt_reg + CW'(1);
               zero_cnt_reg <= zero_next;
            end
         end
      end
   end

   // Holding register: a completing word may replace one leaving on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_data  <= '0;
         out_valid <= 1'b0;
         overflow  <= 1'b0;
      end else if (word_done) begin
         if (!out_valid || out_ready) begin
            out_data  <= asm_shift;
            out_valid <= 1'b1;
         end else begin
            overflow  <= 1'b1;
         end
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_nrzi_rx_deser.sv
// Bench for nrzi_rx_deser: NRZI-encodes bit streams and checks lock, words,
// backpressure, loss of lock, flush and async reset against a word scoreboard.
module tb_nrzi_rx_deser;

   logic       clk = 1'b0;
   logic       rst;
   logic       bit_en;
   logic       line;
   logic       flush;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       locked;
   logic       overflow;

   logic       line_lvl;
   logic [7:0] exp_q[$];
   int         vectors = 0;
   int         miscompares = 0;

   nrzi_rx_deser dut (
      .clk       (clk),
      .rst       (rst),
      .bit_en    (bit_en),
      .line      (line),
      .flush     (flush),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .locked    (locked),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   // Scoreboard: every accepted word must match the next expected word.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         logic [7:0] e;
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_word: got %02h, required none", out_data);
         end else begin
            e = exp_q.pop_front();
            if (out_data !== e) begin
               miscompares++;
               $display("FAIL word: got %02h, required %02h", out_data, e);
            end else begin
               $display("word %02h ok", out_data);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] req);
      vectors++;
      if (got !== req) begin
         miscompares++;
         $display("FAIL %s: got %02h, required %02h", name, got, req);
      end else begin
         $display("%s = %02h ok", name, got);
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      bit_en = 1'b0;
      flush = 1'b0;
      out_ready = 1'b0;
      line_lvl = 1'b0;
      line = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("queue_drained", 8'(exp_q.size()), 8'd0);
      exp_q.delete();
      rst = 1'b1;
   endtask

   task automatic send_bit(input logic b);
      line_lvl = line_lvl ^ b;
      line = line_lvl;
      bit_en = 1'b1;
      @(posedge clk);
      #1;
      bit_en = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w, input int n);
      for (int i = 0; i < n; i++) send_bit(w[i]);
   endtask

   task automatic test_reset();
      do_reset();
      chk("rst_out_data", out_data, 8'h00);
      chk("rst_out_valid", 8'(out_valid), 8'd0);
      chk("rst_locked", 8'(locked), 8'd0);
      chk("rst_overflow", 8'(overflow), 8'd0);
   endtask

   task automatic test_sync_lock();
      do_reset();
      send_word(8'hD5, 7);
      chk("lock_before_last", 8'(locked), 8'd0);
      send_bit(1'b1);
      chk("lock_after_sync", 8'(locked), 8'd1);
      chk("lock_out_valid", 8'(out_valid), 8'd0);
   endtask

   task automatic test_word_receive();
      do_reset();
      send_word(8'hD5, 8);
      out_ready = 1'b1;
      exp_q.push_back(8'h3C);
      send_word(8'h3C, 8);
      chk("rx_valid_hi", 8'(out_valid), 8'd1);
      chk("rx_data", out_data, 8'h3C);
      @(posedge clk);
      #1;
      chk("rx_valid_one_cycle", 8'(out_valid), 8'd0);
      out_ready = 1'b0;
   endtask

   task automatic test_overflow();
      do_reset();
      send_word(8'hD5, 8);
      send_word(8'h3C, 8);
      send_word(8'hA5, 8);
      chk("ovf_data_held", out_data, 8'h3C);
      chk("ovf_flag", 8'(overflow), 8'd1);
      chk("ovf_valid_held", 8'(out_valid), 8'd1);
      exp_q.push_back(8'h3C);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("ovf_drained", 8'(out_valid), 8'd0);
      chk("ovf_sticky", 8'(overflow), 8'd1);
      out_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      do_reset();
      send_word(8'hD5, 8);
      send_word(8'h3C, 8);
      send_word(8'h5A, 7);
      chk("b2b_holding", out_data, 8'h3C);
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'h5A);
      out_ready = 1'b1;
      send_bit(1'b0);
      chk("b2b_data", out_data, 8'h5A);
      chk("b2b_valid", 8'(out_valid), 8'd1);
      chk("b2b_no_ovf", 8'(overflow), 8'd0);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_loss_of_lock();
      do_reset();
      send_word(8'hD5, 8);
      out_ready = 1'b1;
      exp_q.push_back(8'h07);
      exp_q.push_back(8'h00);
      send_word(8'h07, 3);
      for (int i = 0; i < 15; i++) send_bit(1'b0);
      chk("idle_still_locked", 8'(locked), 8'd1);
      send_bit(1'b0);
      chk("idle_unlocked", 8'(locked), 8'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("idle_no_partial", 8'(out_valid), 8'd0);
      send_word(8'hD5, 8);
      chk("idle_relock", 8'(locked), 8'd1);
      out_ready = 1'b0;
   endtask

   task automatic test_flush();
      do_reset();
      send_word(8'hD5, 8);
      send_word(8'h05, 3);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      chk("flush_unlocked", 8'(locked), 8'd0);
      out_ready = 1'b1;
      send_word(8'hD5, 8);
      exp_q.push_back(8'h3C);
      send_word(8'h3C, 8);
      chk("flush_rx_data", out_data, 8'h3C);
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset();
      send_word(8'hD5, 8);
      send_word(8'h3C, 8);
      send_word(8'hFF, 3);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_out_data", out_data, 8'h00);
      chk("arst_out_valid", 8'(out_valid), 8'd0);
      chk("arst_locked", 8'(locked), 8'd0);
      chk("arst_overflow", 8'(overflow), 8'd0);
   endtask

   initial begin
      test_reset();
      test_sync_lock();
      test_word_receive();
      test_overflow();
      test_back_to_back();
      test_loss_of_lock();
      test_flush();
      test_async_reset();
      do_reset();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
